// File: rtl/m_hazard_pkg.sv
// Shared pipeline-control types: WFI sleep states and RV opcode constants
// used by the hazard controller, decoder and CSR unit.
package m_hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2
  } wfi_state_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_MADD    = 7'b1000011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // Opcodes whose load data arrives late enough to create a load-use hazard.
  function automatic logic is_load_opc(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_LOAD_FP);
  endfunction

endpackage

// File: rtl/m_lsu_outst_counter.sv
// Tracks in-flight LSU requests; a full counter still accepts a request
// when an acknowledge frees a slot in the same cycle.
module m_lsu_outst_counter
  import m_hazard_pkg::*;
#(
  parameter  int MAX = 1,
  localparam int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic          ack_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] cnt_nxt_o,
  output logic          accept_o
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // An ack with nothing outstanding is dropped rather than wrapping the count.
  always_comb begin
    accept_o = req_i & ((cnt_q < MAX_C) | ack_i);
    cnt_d    = cnt_q;
    if (accept_o & ~ack_i) begin
      cnt_d = cnt_q + CW'(1);
    end else if (~accept_o & ack_i & (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/m_pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use detection, LSU
// back-pressure, WFI sleep sequencing and redirect arbitration.
module m_pipeline_hazard_ctrl
  import m_hazard_pkg::*;
#(
  parameter  int RA_W          = 5,
  parameter  int NUM_RS        = 2,
  parameter  int LD_USE_LAT    = 1,
  parameter  int LSU_MAX_OUTST = 1,
  localparam int CW            = $clog2(LSU_MAX_OUTST + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RS*RA_W-1:0] id_rs_i,
  input  logic [NUM_RS-1:0]      id_rs_vld_i,
  input  logic [RA_W-1:0]        ex_rd_i,
  input  logic                   ex_memread_i,
  input  logic [RA_W-1:0]        mem_rd_i,
  input  logic                   mem_memread_i,
  input  logic                   exe_pc_req_i,
  input  logic                   csr_pc_req_i,
  input  logic                   wfi_req_i,
  input  logic                   irq_pending_i,
  input  logic                   lsu_req_i,
  input  logic                   lsu_ack_i,
  output logic                   pc_we_o,
  output logic                   if_id_we_o,
  output logic                   id_ex_we_o,
  output logic                   ex_mem_we_o,
  output logic                   if_id_flush_o,
  output logic                   id_ex_flush_o,
  output logic                   ex_mem_flush_o,
  output logic                   exe_pc_req_o,
  output logic                   csr_pc_req_o,
  output logic                   wfi_sleep_o,
  output logic [CW-1:0]          lsu_outst_o
);

  wfi_state_e    state_q;
  wfi_state_e    state_d;
  logic [CW-1:0] lsu_cnt;
  logic [CW-1:0] lsu_cnt_nxt;
  logic          lsu_accept;
  logic          lsu_stall;
  logic          ld_use;

  m_lsu_outst_counter #(
    .MAX (LSU_MAX_OUTST)
  ) u_lsu_outst_counter (
    .clk       (clk),
    .rst       (rst),
    .req_i     (lsu_req_i),
    .ack_i     (lsu_ack_i),
    .cnt_o     (lsu_cnt),
    .cnt_nxt_o (lsu_cnt_nxt),
    .accept_o  (lsu_accept)
  );

  assign lsu_stall   = lsu_req_i & ~lsu_accept;
  assign lsu_outst_o = lsu_cnt;

  // x0 reads are hardwired zero, so a load targeting x0 never blocks a consumer.
  always_comb begin
    ld_use = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (id_rs_vld_i[k] && (id_rs_i[k*RA_W +: RA_W] != '0)) begin
        if ((ex_memread_i && (ex_rd_i == id_rs_i[k*RA_W +: RA_W])) ||
            ((LD_USE_LAT == 2) && mem_memread_i && (mem_rd_i == id_rs_i[k*RA_W +: RA_W]))) begin
          ld_use = 1'b1;
        end
      end
    end
  end

  // DRAIN waits on the post-update count so the final ack moves straight to SLEEP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (wfi_req_i) state_d = (lsu_cnt == '0) ? SLEEP : DRAIN;
      DRAIN:   if (lsu_cnt_nxt == '0) state_d = SLEEP;
      SLEEP:   if (irq_pending_i) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (csr_pc_req_i) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_we_o        = 1'b1;
    if_id_we_o     = 1'b1;
    id_ex_we_o     = 1'b1;
    ex_mem_we_o    = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    exe_pc_req_o   = 1'b0;
    csr_pc_req_o   = 1'b0;
    if (rst) begin
      pc_we_o        = 1'b0;
      if_id_we_o     = 1'b0;
      id_ex_we_o     = 1'b0;
      ex_mem_we_o    = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
    end else if (csr_pc_req_i) begin
      csr_pc_req_o   = 1'b1;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
    end else if (lsu_stall) begin
      // Freeze everything; a pending EX redirect is re-presented next cycle.
      pc_we_o     = 1'b0;
      if_id_we_o  = 1'b0;
      id_ex_we_o  = 1'b0;
      ex_mem_we_o = 1'b0;
    end else if ((state_q != RUN) || wfi_req_i) begin
      pc_we_o       = 1'b0;
      if_id_we_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end else if (exe_pc_req_i) begin
      exe_pc_req_o  = 1'b1;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (ld_use) begin
      pc_we_o       = 1'b0;
      if_id_we_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  assign wfi_sleep_o = ~rst & (state_q == SLEEP);

endmodule

// File: tb/tb_m_pipeline_hazard_ctrl.sv
// Directed bench for m_pipeline_hazard_ctrl with a per-cycle behavioural model
// (2 source regs, 2-stage load latency, 2 outstanding LSU requests).
module tb_m_pipeline_hazard_ctrl;

  localparam int RA_W = 5;
  localparam int NUM_RS = 2;
  localparam int LAT = 2;
  localparam int MAX = 2;
  localparam int M_RUN = 0;
  localparam int M_DRAIN = 1;
  localparam int M_SLEEP = 2;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] vld;
    logic [4:0] ex_rd;
    logic       ex_mr;
    logic [4:0] mem_rd;
    logic       mem_mr;
    logic       exe;
    logic       csr;
    logic       wfi;
    logic       irq;
    logic       req;
    logic       ack;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs0, rs1, ex_rd, mem_rd;
  logic [1:0] vld;
  logic ex_mr, mem_mr, exe, csr, wfi, irq, req, ack;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic if_id_flush, id_ex_flush, ex_mem_flush;
  logic exe_o, csr_o, sleep;
  logic [1:0] outst;

  int checks = 0;
  int failures = 0;
  int m_cnt = 0;
  int m_state = M_RUN;
  stim_t s;

  m_pipeline_hazard_ctrl #(
    .RA_W          (RA_W),
    .NUM_RS        (NUM_RS),
    .LD_USE_LAT    (LAT),
    .LSU_MAX_OUTST (MAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs_i        ({rs1, rs0}),
    .id_rs_vld_i    (vld),
    .ex_rd_i        (ex_rd),
    .ex_memread_i   (ex_mr),
    .mem_rd_i       (mem_rd),
    .mem_memread_i  (mem_mr),
    .exe_pc_req_i   (exe),
    .csr_pc_req_i   (csr),
    .wfi_req_i      (wfi),
    .irq_pending_i  (irq),
    .lsu_req_i      (req),
    .lsu_ack_i      (ack),
    .pc_we_o        (pc_we),
    .if_id_we_o     (if_id_we),
    .id_ex_we_o     (id_ex_we),
    .ex_mem_we_o    (ex_mem_we),
    .if_id_flush_o  (if_id_flush),
    .id_ex_flush_o  (id_ex_flush),
    .ex_mem_flush_o (ex_mem_flush),
    .exe_pc_req_o   (exe_o),
    .csr_pc_req_o   (csr_o),
    .wfi_sleep_o    (sleep),
    .lsu_outst_o    (outst)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic bit model_ld_use();
    bit hit = 0;
    for (int k = 0; k < NUM_RS; k++) begin
      logic [4:0] r = (k == 0) ? rs0 : rs1;
      if (vld[k] && r != 0 && ((ex_mr && ex_rd == r) || (LAT == 2 && mem_mr && mem_rd == r)))
        hit = 1;
    end
    return hit;
  endfunction

  function automatic bit model_accept(int c);
    return req && (c < MAX || ack);
  endfunction

  function automatic int model_next_cnt(int c);
    bit acc = model_accept(c);
    if (acc && !ack) return c + 1;
    if (!acc && ack && c > 0) return c - 1;
    return c;
  endfunction

  function automatic int model_next_state(int st, int c);
    int nc = model_next_cnt(c);
    int ns = st;
    if (st == M_RUN && wfi) ns = (c == 0) ? M_SLEEP : M_DRAIN;
    else if (st == M_DRAIN && nc == 0) ns = M_SLEEP;
    else if (st == M_SLEEP && irq) ns = M_RUN;
    if (csr) ns = M_RUN;
    return ns;
  endfunction

  // {pc,if_id,id_ex,ex_mem we, if_id,id_ex,ex_mem flush, exe_o, csr_o, sleep}
  function automatic logic [9:0] model_outputs();
    logic [9:0] v;
    bit stall = req && !model_accept(m_cnt);
    if (rst)                               v = 10'b0000_111_00_0;
    else if (csr)                          v = 10'b1111_111_01_0;
    else if (stall)                        v = 10'b0000_000_00_0;
    else if (m_state != M_RUN || wfi)      v = 10'b0011_010_00_0;
    else if (exe)                          v = 10'b1111_110_10_0;
    else if (model_ld_use())               v = 10'b0011_010_00_0;
    else                                   v = 10'b1111_000_00_0;
    v[0] = !rst && m_state == M_SLEEP;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt   <= 0;
      m_state <= M_RUN;
    end else begin
      m_cnt   <= model_next_cnt(m_cnt);
      m_state <= model_next_state(m_state, m_cnt);
    end
  end

  always @(negedge clk) begin
    logic [9:0] act;
    logic [9:0] exp_v;
    act = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush,
           ex_mem_flush, exe_o, csr_o, sleep};
    exp_v = model_outputs();
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL model_ctrl t=%0t: got %b expected %b", $time, act, exp_v);
    end
    checks++;
    if (outst !== 2'(m_cnt)) begin
      failures++;
      $display("[TB] FAIL model_outst t=%0t: got %0d expected %0d", $time, outst, m_cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic stim_t idle();
    stim_t t = '0;
    return t;
  endfunction

  task automatic drive(input stim_t t);
    rst = t.rst; rs0 = t.rs0; rs1 = t.rs1; vld = t.vld;
    ex_rd = t.ex_rd; ex_mr = t.ex_mr; mem_rd = t.mem_rd; mem_mr = t.mem_mr;
    exe = t.exe; csr = t.csr; wfi = t.wfi; irq = t.irq; req = t.req; ack = t.ack;
  endtask

  task automatic applyStimulus(input stim_t t);
    @(posedge clk);
    #1;
    drive(t);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  initial begin
    s = idle();
    s.rst = 1'b1;
    drive(s);
    applyStimulus(s);
    applyStimulus(s);
    checkOutput("rst_we", {4'b0, pc_we, if_id_we, id_ex_we, ex_mem_we}, 8'h00);
    checkOutput("rst_flush", {5'b0, if_id_flush, id_ex_flush, ex_mem_flush}, 8'h07);
    checkOutput("rst_redirect", {6'b0, exe_o, csr_o}, 8'h00);

    s = idle();
    applyStimulus(s);
    checkOutput("idle_we", {4'b0, pc_we, if_id_we, id_ex_we, ex_mem_we}, 8'h0f);
    checkOutput("idle_outst", 8'(outst), 8'd0);

    // T1: EX load feeding rs1, then x0 never hazards
    s = idle(); s.ex_mr = 1; s.ex_rd = 5; s.rs0 = 5; s.vld = 2'b01;
    applyStimulus(s);
    checkOutput("t1_stall", {5'b0, pc_we, if_id_we, id_ex_flush}, 8'h01);
    checkOutput("t1_exmem_we", 8'(ex_mem_we), 8'd1);
    s = idle(); s.ex_mr = 1; s.ex_rd = 0; s.rs0 = 0; s.vld = 2'b01;
    applyStimulus(s);
    checkOutput("t1_x0", {5'b0, pc_we, if_id_we, id_ex_flush}, 8'h06);

    // T2: MEM load feeding rs2, only when rs2 is really read
    s = idle(); s.mem_mr = 1; s.mem_rd = 7; s.rs1 = 7; s.vld = 2'b10;
    applyStimulus(s);
    checkOutput("t2_stall", {5'b0, pc_we, if_id_we, id_ex_flush}, 8'h01);
    s.vld = 2'b00;
    applyStimulus(s);
    checkOutput("t2_novld", {5'b0, pc_we, if_id_we, id_ex_flush}, 8'h06);

    // T3: fill the LSU, overflow stall masks a redirect, then req+ack at full
    s = idle(); s.req = 1;
    applyStimulus(s);
    checkOutput("t3_c0", 8'(outst), 8'd0);
    applyStimulus(s);
    checkOutput("t3_c1", 8'(outst), 8'd1);
    s.exe = 1;
    applyStimulus(s);
    checkOutput("t3_c2", 8'(outst), 8'd2);
    checkOutput("t3_full_we", {4'b0, pc_we, if_id_we, id_ex_we, ex_mem_we}, 8'h00);
    checkOutput("t3_full_exe", 8'(exe_o), 8'd0);
    s = idle(); s.req = 1; s.ack = 1;
    applyStimulus(s);
    checkOutput("t3_reqack_we", 8'(pc_we), 8'd1);
    s = idle(); s.ack = 1;
    applyStimulus(s);
    checkOutput("t3_hold", 8'(outst), 8'd2);

    // T4: WFI with one outstanding -> DRAIN -> SLEEP -> wake
    s = idle(); s.wfi = 1;
    applyStimulus(s);
    checkOutput("t4_wfi_cnt", 8'(outst), 8'd1);
    checkOutput("t4_wfi_pc", 8'(pc_we), 8'd0);
    s = idle(); s.ack = 1;
    applyStimulus(s);
    checkOutput("t4_drain", {5'b0, pc_we, id_ex_flush, sleep}, 8'h02);
    s = idle();
    applyStimulus(s);
    checkOutput("t4_sleep", {5'b0, pc_we, id_ex_flush, sleep}, 8'h03);
    s.irq = 1;
    applyStimulus(s);
    checkOutput("t4_irq_cycle", 8'(sleep), 8'd1);
    s = idle();
    applyStimulus(s);
    checkOutput("t4_wake", {6'b0, pc_we, sleep}, 8'h02);

    // Ack with nothing outstanding is dropped
    s = idle(); s.ack = 1;
    applyStimulus(s);
    s = idle();
    applyStimulus(s);
    checkOutput("ack_underflow", 8'(outst), 8'd0);

    // EX redirect wins over load-use
    s = idle(); s.ex_mr = 1; s.ex_rd = 3; s.rs0 = 3; s.vld = 2'b01; s.exe = 1;
    applyStimulus(s);
    checkOutput("exe_vs_lduse", {3'b0, exe_o, pc_we, if_id_flush, id_ex_flush, ex_mem_flush}, 8'h1e);

    // T5: CSR redirect beats EX redirect and load-use
    s.csr = 1;
    applyStimulus(s);
    checkOutput("t5_redirect", {6'b0, exe_o, csr_o}, 8'h01);
    checkOutput("t5_flush", {5'b0, if_id_flush, id_ex_flush, ex_mem_flush}, 8'h07);

    // T6: reset in the middle of DRAIN with two outstanding
    s = idle(); s.req = 1;
    applyStimulus(s);
    applyStimulus(s);
    s = idle(); s.wfi = 1;
    applyStimulus(s);
    checkOutput("t6_pre_cnt", 8'(outst), 8'd2);
    s = idle(); s.rst = 1;
    applyStimulus(s);
    checkOutput("t6_rst_flush", {5'b0, if_id_flush, id_ex_flush, ex_mem_flush}, 8'h07);
    checkOutput("t6_rst_sleep", 8'(sleep), 8'd0);
    s = idle();
    applyStimulus(s);
    checkOutput("t6_post_cnt", 8'(outst), 8'd0);
    checkOutput("t6_post_run", {6'b0, pc_we, sleep}, 8'h02);

    applyStimulus(idle());
    #10;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
